// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the execute-stage flag/branch back end: opcodes, condition
// codes, FSM states, the flag triple and the per-opcode flag write mask.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    C_NE = 3'd0,
    C_EQ = 3'd1,
    C_GT = 3'd2,
    C_LT = 3'd3,
    C_GE = 3'd4,
    C_LE = 3'd5,
    C_OV = 3'd6,
    C_UN = 3'd7
  } cond_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_t;

  typedef struct packed {
    logic N;
    logic Z;
    logic V;
  } flag_t;

  // Write mask ordered {N,Z,V}, matching flag_t packing
  function automatic logic [2:0] writes_flags(input op_t op);
    logic [2:0] mask;
    mask = '0;
    case (op)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b010;
      default:                        mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage result and branch-request bundle between the pipeline and the
// flag/branch back end.
interface flag_branch_unit_if #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  logic              alu_valid;
  wisc_pkg::op_t     alu_op;
  logic [DW-1:0]     alu_sum;
  logic              alu_N;
  logic              alu_Z;
  logic              alu_V;
  logic              br_valid;
  wisc_pkg::cond_t   br_cond;
  logic              br_ready;
  logic              br_done;
  logic              br_taken;
  logic [DW-1:0]     res_q;
  logic              res_valid;
  logic              flag_N;
  logic              flag_Z;
  logic              flag_V;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output alu_valid, alu_op, alu_sum, alu_N, alu_Z, alu_V, br_valid, br_cond,
    input  br_ready, br_done, br_taken, res_q, res_valid,
           flag_N, flag_Z, flag_V, br_cnt, taken_cnt
  );

  modport slave (
    input  alu_valid, alu_op, alu_sum, alu_N, alu_Z, alu_V, br_valid, br_cond,
    output br_ready, br_done, br_taken, res_q, res_valid,
           flag_N, flag_Z, flag_V, br_cnt, taken_cnt
  );
endinterface

// File: rtl/flag_branch_unit_br_cond_eval.sv
// Combinational branch condition resolver: condition code against N/Z/V.
module br_cond_eval
  import wisc_pkg::*;
(
  input  cond_t cond_i,
  input  flag_t flags_i,
  output logic  taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      C_NE: taken_o = ~flags_i.Z;
      C_EQ: taken_o = flags_i.Z;
      C_GT: taken_o = ~flags_i.Z & ~flags_i.N;
      C_LT: taken_o = flags_i.N;
      C_GE: taken_o = flags_i.Z | ~flags_i.N;
      C_LE: taken_o = flags_i.N | flags_i.Z;
      C_OV: taken_o = flags_i.V;
      C_UN: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// EX/MEM result register, architectural N/Z/V flags and branch resolution
// with a one-cycle hold when the same-cycle EX instruction writes flags.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  flag_branch_unit_if.slave  bus
);

  logic             accept;
  logic [2:0]       wmask;
  logic             wr_flags;
  flag_t            alu_flags;
  flag_t            flags_q, flags_d;
  logic [DW-1:0]    res_data_q;
  logic             res_valid_q;
  fsm_t             state_q, state_d;
  cond_t            cond_q, cond_d, eval_cond;
  logic             eval_taken;
  logic             br_ready;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    accept    = bus.alu_valid & ~stall & ~flush;
    wmask     = accept ? writes_flags(bus.alu_op) : '0;
    wr_flags  = |wmask;
    alu_flags = '{N: bus.alu_N, Z: bus.alu_Z, V: bus.alu_V};
    flags_d   = (flags_q & ~wmask) | (alu_flags & wmask);
  end

  br_cond_eval u_eval (
    .cond_i  (eval_cond),
    .flags_i (flags_q),
    .taken_o (eval_taken)
  );

  // Both resolve paths read flags_q: in WAIT it already holds the flags
  // written by the instruction that caused the hold.
  always_comb begin
    state_d   = state_q;
    cond_d    = cond_q;
    done_d    = 1'b0;
    taken_d   = taken_q;
    br_ready  = 1'b0;
    eval_cond = bus.br_cond;
    case (state_q)
      IDLE: begin
        br_ready = rst_n & ~stall & ~flush;
        if (bus.br_valid && br_ready) begin
          if (wr_flags) begin
            cond_d  = bus.br_cond;
            state_d = WAIT;
          end else begin
            done_d  = 1'b1;
            taken_d = eval_taken;
          end
        end
      end
      WAIT: begin
        eval_cond = cond_q;
        if (flush) begin
          state_d = IDLE;
        end else if (!stall) begin
          done_d  = 1'b1;
          taken_d = eval_taken;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (done_d && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 1'b1;
    if (done_d && taken_d && (taken_cnt_q != '1))
      taken_cnt_d = taken_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      flags_q     <= '0;
      state_q     <= IDLE;
      cond_q      <= C_NE;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (!stall)
        res_data_q <= bus.alu_sum;
      if (flush)
        res_valid_q <= 1'b0;
      else if (!stall)
        res_valid_q <= accept;
      flags_q     <= flags_d;
      state_q     <= state_d;
      cond_q      <= cond_d;
      done_q      <= done_d;
      taken_q     <= taken_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.br_ready  = br_ready;
  assign bus.br_done   = done_q;
  assign bus.br_taken  = taken_q;
  assign bus.res_q     = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.flag_N    = flags_q.N;
  assign bus.flag_Z    = flags_q.Z;
  assign bus.flag_V    = flags_q.V;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule
